// File: rtl/inst_rom_ctrl.sv
// Instruction ROM controller: a loader fills a 2^AW-word program memory,
// then the CPU is released from reset and fetches from it with one-cycle latency.
//
// Ports:
//   clk, resetn        clock; synchronous active-low reset
//   inst_addr  [31:0]  fetch byte address (virtual, kseg1)
//   inst       [31:0]  registered instruction word for the previous address
//   addr_err           registered; fetch at the previous address was illegal
//   load_valid         loader presents load_data
//   load_data  [31:0]  program word
//   load_ready         controller accepts a program word this cycle
//   load_done          loader finished; enter RUN
//   load_count [AW:0]  words written since entering LOAD
//   load_ovf           sticky; loader pushed a word into a full memory
//   cpu_resetn         registered active-low reset to the CPU
module inst_rom_ctrl #(
   parameter int          AW    = 10,
   parameter logic [31:0] PBASE = 32'h1FC0_0000
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic [31:0]   inst_addr,
   output logic [31:0]   inst,
   output logic          addr_err,
   input  logic          load_valid,
   input  logic [31:0]   load_data,
   output logic          load_ready,
   input  logic          load_done,
   output logic [AW:0]   load_count,
   output logic          load_ovf,
   output logic          cpu_resetn
);

   localparam int DEPTH = 1 << AW;

   localparam logic [0:0] ST_LOAD = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [31:0] mem [DEPTH];

   logic [0:0]  state_q;
   logic [0:0]  state_d;
   logic [AW:0] load_count_q;
   logic [AW:0] load_count_d;
   logic        load_ovf_q;
   logic        load_ovf_d;
   logic        cpu_resetn_q;
   logic        cpu_resetn_d;
   logic [31:0] inst_q;
   logic [31:0] inst_d;
   logic        addr_err_q;
   logic        addr_err_d;

   logic        in_load;
   logic        in_run;
   logic        cnt_full;
   logic        wr_en;

   logic [31:0]   phys_addr;
   logic          kseg1_ok;
   logic          window_ok;
   logic          align_ok;
   logic          fetch_legal;
   logic [AW-1:0] rd_idx;

   always_comb begin
      in_load  = (state_q == ST_LOAD);
      in_run   = (state_q == ST_RUN);
      // MSB of the counter is set exactly when all 2^AW words are written
      cnt_full = load_count_q[AW];
   end

   // Gated by resetn so the loader never sees ready during reset
   assign load_ready = resetn & in_load & ~cnt_full;
   assign wr_en      = load_valid & load_ready;

   // kseg1 strip, then window/alignment check on the physical address
   always_comb begin
      phys_addr   = {3'b000, inst_addr[28:0]};
      kseg1_ok    = (inst_addr[31:29] == 3'b101);
      window_ok   = (phys_addr[31:AW+2] == PBASE[31:AW+2]);
      align_ok    = (phys_addr[1:0] == 2'b00);
      fetch_legal = kseg1_ok & window_ok & align_ok;
      rd_idx      = phys_addr[AW+1:2];
   end

   always_comb begin
      state_d = state_q;
      // A word offered together with load_done is still written this cycle
      if (in_load && load_done) begin
         state_d = ST_RUN;
      end
   end

   always_comb begin
      load_count_d = load_count_q + {{AW{1'b0}}, wr_en};
      load_ovf_d   = load_ovf_q | (in_load & load_valid & cnt_full);
      cpu_resetn_d = in_run;
   end

   // No writes happen in RUN, so reads never collide with the loader
   always_comb begin
      inst_d     = 32'h0;
      addr_err_d = 1'b0;
      if (in_run) begin
         addr_err_d = ~fetch_legal;
         if (fetch_legal) begin
            inst_d = mem[rd_idx];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q      <= ST_LOAD;
         load_count_q <= '0;
         load_ovf_q   <= 1'b0;
         cpu_resetn_q <= 1'b0;
         inst_q       <= 32'h0;
         addr_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         load_count_q <= load_count_d;
         load_ovf_q   <= load_ovf_d;
         cpu_resetn_q <= cpu_resetn_d;
         inst_q       <= inst_d;
         addr_err_q   <= addr_err_d;
      end
   end

   // Program memory is deliberately left out of reset so it survives
   // a CPU restart without reloading
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[load_count_q[AW-1:0]] <= load_data;
      end
   end

   assign inst       = inst_q;
   assign addr_err   = addr_err_q;
   assign load_count = load_count_q;
   assign load_ovf   = load_ovf_q;
   assign cpu_resetn = cpu_resetn_q;

endmodule

// File: tb/tb_inst_rom_ctrl.sv
// Scoreboard bench for inst_rom_ctrl: a behavioural model predicts every
// cycle's outputs, a monitor process compares them after each clock edge.
module tb_inst_rom_ctrl;

   localparam int          AW    = 10;
   localparam int          DEPTH = 1 << AW;
   localparam logic [31:0] PBASE = 32'h1FC0_0000;

   logic          clk;
   logic          resetn;
   logic [31:0]   inst_addr;
   logic [31:0]   inst;
   logic          addr_err;
   logic          load_valid;
   logic [31:0]   load_data;
   logic          load_ready;
   logic          load_done;
   logic [AW:0]   load_count;
   logic          load_ovf;
   logic          cpu_resetn;

   inst_rom_ctrl #(.AW(AW), .PBASE(PBASE)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .inst_addr  (inst_addr),
      .inst       (inst),
      .addr_err   (addr_err),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_ready (load_ready),
      .load_done  (load_done),
      .load_count (load_count),
      .load_ovf   (load_ovf),
      .cpu_resetn (cpu_resetn)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] inst;
      bit          inst_known;
      bit          err;
      bit          cpu;
      logic [AW:0] count;
      bit          ovf;
      bit          ready;
   } exp_t;

   exp_t sb_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   bit          m_run   = 1'b0;
   int          m_count = 0;
   bit          m_ovf   = 1'b0;
   logic [31:0] m_mem [int];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Legal fetch: kseg1 address, word aligned, inside the physical window
   function automatic bit fetch_ok(input logic [31:0] a, output int idx);
      longint unsigned phys;
      idx = 0;
      if (a < 32'hA000_0000 || a >= 32'hC000_0000) return 1'b0;
      if (a % 4 != 0) return 1'b0;
      phys = longint'(a) - 64'hA000_0000;
      if (phys < PBASE || phys >= longint'(PBASE) + 4 * DEPTH) return 1'b0;
      idx = int'((phys - PBASE) / 4);
      return 1'b1;
   endfunction

   function automatic logic [31:0] gen_addr();
      int m = $urandom_range(0, 6);
      case (m)
         0, 1, 2: return 32'hBFC0_0000 + 4 * $urandom_range(0, 7);
         3:       return 32'hBFC0_0000 + 4 * $urandom_range(0, DEPTH - 1);
         4:       return 32'h9FC0_0000 + 4 * $urandom_range(0, 7);
         5:       return 32'hBFC0_0000 + $urandom_range(0, 31);
         default: return $urandom;
      endcase
   endfunction

   // Drive one cycle of inputs and push the model's prediction for it
   task automatic cycle(input bit rn, input bit lv, input logic [31:0] ld,
                        input bit dn, input logic [31:0] ia);
      exp_t e;
      int   idx;
      @(negedge clk);
      resetn     = rn;
      load_valid = lv;
      load_data  = ld;
      load_done  = dn;
      inst_addr  = ia;
      e.inst       = 32'h0;
      e.inst_known = 1'b1;
      e.err        = 1'b0;
      e.cpu        = 1'b0;
      if (!rn) begin
         m_run   = 1'b0;
         m_count = 0;
         m_ovf   = 1'b0;
      end else begin
         e.cpu = m_run;
         if (m_run) begin
            if (fetch_ok(ia, idx)) begin
               if (m_mem.exists(idx)) e.inst = m_mem[idx];
               else e.inst_known = 1'b0;
            end else begin
               e.err = 1'b1;
            end
         end else begin
            if (lv) begin
               if (m_count < DEPTH) begin
                  m_mem[m_count] = ld;
                  m_count++;
               end else begin
                  m_ovf = 1'b1;
               end
            end
            if (dn) m_run = 1'b1;
         end
      end
      e.count = m_count[AW:0];
      e.ovf   = m_ovf;
      e.ready = rn && !m_run && (m_count < DEPTH);
      sb_q.push_back(e);
   endtask

   exp_t mon_e;

   always @(posedge clk) begin
      #2;
      if (sb_q.size() > 0) begin
         mon_e = sb_q.pop_front();
         if (mon_e.inst_known) chk("inst", inst, mon_e.inst);
         chk("addr_err", {31'b0, addr_err}, {31'b0, mon_e.err});
         chk("cpu_resetn", {31'b0, cpu_resetn}, {31'b0, mon_e.cpu});
         chk("load_count", {21'b0, load_count}, {21'b0, mon_e.count});
         chk("load_ovf", {31'b0, load_ovf}, {31'b0, mon_e.ovf});
         chk("load_ready", {31'b0, load_ready}, {31'b0, mon_e.ready});
      end
   end

   logic [31:0] prog [4];
   int          waitc;

   initial begin
      resetn     = 1'b0;
      load_valid = 1'b0;
      load_data  = 32'h0;
      load_done  = 1'b0;
      inst_addr  = 32'h0;
      prog[0] = 32'h2408_0001;
      prog[1] = 32'h2409_0002;
      prog[2] = 32'h0109_5020;
      prog[3] = 32'h0000_0000;

      repeat (2) cycle(0, 1, $urandom, 0, gen_addr());

      // Short program load with LOAD-phase address sweep
      for (int i = 0; i < 4; i++) begin
         cycle(1, 1, prog[i], 0, gen_addr());
         cycle(1, 0, $urandom, 0, gen_addr());
      end
      cycle(1, 0, 32'h0, 1, gen_addr());
      cycle(1, 0, 32'h0, 0, 32'hBFC0_0008);
      cycle(1, 0, 32'h0, 0, 32'h9FC0_0000);
      cycle(1, 0, 32'h0, 0, 32'hBFC0_0002);
      cycle(1, 0, 32'h0, 0, 32'hBFC0_1000);
      cycle(1, 0, 32'h0, 0, 32'hBFC0_000C);
      for (int i = 0; i < 20; i++)
         cycle(1, $urandom_range(0, 1), $urandom, $urandom_range(0, 1), gen_addr());

      // One-cycle reset in RUN, then RUN again with no writes
      cycle(0, 0, 32'h0, 0, 32'hBFC0_0008);
      cycle(1, 0, 32'h0, 0, 32'hBFC0_0008);
      cycle(1, 0, 32'h0, 1, gen_addr());
      cycle(1, 0, 32'h0, 0, 32'hBFC0_0008);
      cycle(1, 0, 32'h0, 0, 32'hBFC0_0008);
      for (int i = 0; i < 10; i++) cycle(1, 0, 32'h0, 0, gen_addr());

      // Reset aborts a partial load; next load restarts at word 0
      cycle(0, 0, 32'h0, 0, gen_addr());
      for (int i = 0; i < 3; i++) cycle(1, 1, $urandom, 0, gen_addr());
      cycle(0, 1, $urandom, 0, gen_addr());
      while (m_count < 7)
         cycle(1, $urandom_range(0, 1), $urandom, 0, gen_addr());
      cycle(1, 1, 32'hCAFE_0007, 1, gen_addr());
      cycle(1, 0, 32'h0, 0, 32'hBFC0_001C);
      for (int i = 0; i < 8; i++) cycle(1, 0, 32'h0, 0, 32'hBFC0_0000 + 4 * i);
      for (int i = 0; i < 15; i++) cycle(1, 0, 32'h0, 0, gen_addr());

      // Fill the whole memory plus overflow attempts
      cycle(0, 0, 32'h0, 0, gen_addr());
      for (int i = 0; i < DEPTH + 1; i++) cycle(1, 1, $urandom, 0, gen_addr());
      for (int i = 0; i < 3; i++) cycle(1, 1, $urandom, 0, gen_addr());
      cycle(1, 0, 32'h0, 1, gen_addr());
      cycle(1, 0, 32'h0, 0, 32'hBFC0_0000);
      cycle(1, 0, 32'h0, 0, 32'hBFC0_0FFC);
      cycle(1, 0, 32'h0, 0, 32'hBFC0_1000);
      for (int i = 0; i < 30; i++) cycle(1, 1, $urandom, 0, gen_addr());

      waitc = 0;
      while (sb_q.size() > 0 && waitc < 10) begin
         @(negedge clk);
         waitc++;
      end
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
